// File: rtl/vector_checker.sv
// vector_checker: table-driven stimulus player and response checker
// for small gate-level DUTs; reports mismatches and first failure.
module vector_checker #(
  parameter int IN_W    = 2,
  parameter int OUT_W   = 1,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_we,
  input  logic [$clog2(DEPTH)-1:0]   load_addr,
  input  logic [OUT_W+IN_W-1:0]      load_data,
  input  logic                       start,
  input  logic                       abort,
  output logic [IN_W-1:0]            dut_in,
  input  logic [OUT_W-1:0]           dut_out,
  output logic                       running,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH+1)-1:0] mismatch_count,
  output logic [$clog2(DEPTH)-1:0]   first_fail_idx
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MW   = $clog2(DEPTH+1);
  localparam int CW   = $clog2(DEPTH+LATENCY+1);
  localparam int LAST = DEPTH + LATENCY - 1;
  localparam int PL   = (LATENCY > 0) ? LATENCY : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic             v;
    logic [AW-1:0]    idx;
    logic [OUT_W-1:0] exp;
  } stage_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cyc;
  logic [OUT_W+IN_W-1:0]   mem [DEPTH];
  logic [OUT_W+IN_W-1:0]   cur_word;
  logic                    issuing;
  logic                    start_run;
  logic                    last;
  logic                    mismatch;
  stage_t                  cur;
  stage_t                  cmp;
  stage_t                  pipe [PL];

  assign issuing   = (state == RUN) && (cyc < CW'(DEPTH));
  assign cur_word  = mem[cyc[AW-1:0]];
  assign start_run = (state != RUN) && start;
  assign last      = (cyc == CW'(LAST));

  assign cur.v   = issuing;
  assign cur.idx = cyc[AW-1:0];
  assign cur.exp = cur_word[OUT_W+IN_W-1:IN_W];

  assign dut_in  = issuing ? cur_word[IN_W-1:0] : '0;
  assign running = (state == RUN);
  assign done    = (state == DONE);
  assign pass    = done && (mismatch_count == '0);

  // Table writes only outside a run; out-of-range addresses dropped.
  always_ff @(posedge clk) begin
    if (load_we && (state != RUN) && (32'(load_addr) < DEPTH))
      mem[load_addr] <= load_data;
  end

  generate
    if (LATENCY == 0) begin : g_nolat
      assign cmp = cur;
      always_comb pipe[0] = '0;
    end else begin : g_lat
      assign cmp = pipe[LATENCY-1];
      // Delay expected values to line up with the DUT pipeline.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else if (state != RUN) begin
          for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= cur;
          for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
      end
    end
  endgenerate

  assign mismatch = (state == RUN) && cmp.v && (cmp.exp != dut_out);

  // Next-state logic: abort beats start/finish inside a run.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = RUN;
      RUN: begin
        if (abort)     state_n = IDLE;
        else if (last) state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, cycle counter and mismatch bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      cyc            <= '0;
      mismatch_count <= '0;
      first_fail_idx <= '0;
    end else begin
      state <= state_n;
      if (start_run) begin
        cyc            <= '0;
        mismatch_count <= '0;
        first_fail_idx <= '0;
      end else if (state == RUN) begin
        if (!last) cyc <= cyc + 1'b1;
        if (mismatch) begin
          if (mismatch_count == '0)
            first_fail_idx <= cmp.idx;
          if (mismatch_count != MW'(DEPTH))
            mismatch_count <= mismatch_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker: directed runs of the NAND truth table against
// good, AND and stuck DUT models at latency 0 and 2.
module tb_vector_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_we;
  logic [1:0] load_addr;
  logic [2:0] load_data;
  logic       start;
  logic       abort;

  logic [1:0] dut_in0, dut_in2;
  logic       dut_out0, dut_out2;
  logic       running0, done0, pass0;
  logic       running2, done2, pass2;
  logic [2:0] mm0, mm2;
  logic [1:0] ffi0, ffi2;

  logic [1:0] mode;
  logic       r1, r2;

  int n_run  = 0;
  int n_fail = 0;

  logic [2:0] tbl [4];
  logic [1:0] stim [4];

  always #5 clk = ~clk;

  vector_checker #(.IN_W(2), .OUT_W(1), .DEPTH(4), .LATENCY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data),
    .start(start), .abort(abort),
    .dut_in(dut_in0), .dut_out(dut_out0),
    .running(running0), .done(done0), .pass(pass0),
    .mismatch_count(mm0), .first_fail_idx(ffi0)
  );

  vector_checker #(.IN_W(2), .OUT_W(1), .DEPTH(4), .LATENCY(2)) u2 (
    .clk(clk), .rst_n(rst_n), .load_we(load_we),
    .load_addr(load_addr), .load_data(load_data),
    .start(start), .abort(abort),
    .dut_in(dut_in2), .dut_out(dut_out2),
    .running(running2), .done(done2), .pass(pass2),
    .mismatch_count(mm2), .first_fail_idx(ffi2)
  );

  always_comb begin
    dut_out0 = 1'b0;
    case (mode)
      2'd0: dut_out0 = ~(dut_in0[1] & dut_in0[0]);
      2'd1: dut_out0 = dut_in0[1] & dut_in0[0];
      default: dut_out0 = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    r1 <= ~(dut_in2[1] & dut_in2[0]);
    r2 <= r1;
  end
  assign dut_out2 = r2;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [1:0] a, input logic [2:0] d);
    @(negedge clk);
    load_we = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_we = 1'b0;
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!(done0 && done2) && t < 30) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_timeout"}, 32'(t < 30), 32'd1);
  endtask

  initial begin
    int nrun2;
    tbl[0] = 3'b100; tbl[1] = 3'b110;
    tbl[2] = 3'b101; tbl[3] = 3'b011;
    for (int i = 0; i < 4; i++) stim[i] = tbl[i][1:0];
    rst_n = 1'b0; load_we = 1'b0; load_addr = '0;
    load_data = '0; start = 1'b0; abort = 1'b0; mode = 2'd0;
    #1;
    chk("rst_running", 32'(running0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_pass", 32'(pass0), 32'd0);
    chk("rst_mm", 32'(mm0), 32'd0);
    chk("rst_ffi", 32'(ffi0), 32'd0);
    chk("rst_dut_in", 32'(dut_in0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) do_load(2'(i), tbl[i]);

    // NAND run, checking the issue sequence cycle by cycle
    pulse_start;
    nrun2 = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) chk($sformatf("nand_in%0d", k), 32'(dut_in0), 32'(stim[k]));
      if (k < 4) chk($sformatf("nand_in2_%0d", k), 32'(dut_in2), 32'(stim[k]));
      if (k == 0) chk("nand_run0", 32'(running0), 32'd1);
      if (k == 3) chk("nand_done_early", 32'(done0), 32'd0);
      if (k == 4) begin
        chk("nand_in_idle", 32'(dut_in0), 32'd0);
        chk("nand_done", 32'(done0), 32'd1);
        chk("nand_pass", 32'(pass0), 32'd1);
        chk("nand_mm", 32'(mm0), 32'd0);
      end
      if (k == 5) chk("l2_done_early", 32'(done2), 32'd0);
      if (k == 6) chk("l2_done", 32'(done2), 32'd1);
      if (running2) nrun2++;
      @(negedge clk);
    end
    chk("l2_run_cycles", 32'(nrun2), 32'd6);
    chk("l2_pass", 32'(pass2), 32'd1);

    // AND DUT: every vector fails
    mode = 2'd1;
    pulse_start;
    chk("and_done_drop", 32'(done0), 32'd0);
    wait_done("and");
    chk("and_mm", 32'(mm0), 32'd4);
    chk("and_ffi", 32'(ffi0), 32'd0);
    chk("and_pass", 32'(pass0), 32'd0);

    // stuck-at-1 DUT: only the last vector fails
    mode = 2'd2;
    pulse_start;
    wait_done("stuck");
    chk("stuck_mm", 32'(mm0), 32'd1);
    chk("stuck_ffi", 32'(ffi0), 32'd3);
    chk("stuck_pass", 32'(pass0), 32'd0);

    // abort sampled at E2, with a table write attempted mid-run
    mode = 2'd0;
    pulse_start;
    load_we = 1'b1; load_addr = 2'd0; load_data = 3'b011;
    @(negedge clk);
    load_we = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_running", 32'(running0), 32'd0);
    chk("abort_done", 32'(done0), 32'd0);
    chk("abort_dut_in", 32'(dut_in0), 32'd0);
    chk("abort_running2", 32'(running2), 32'd0);
    pulse_start;
    wait_done("restart");
    chk("restart_pass", 32'(pass0), 32'd1);
    chk("restart_pass2", 32'(pass2), 32'd1);

    // asynchronous reset mid-run
    pulse_start;
    @(negedge clk);
    @(negedge clk);
    chk("mid_running", 32'(running0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_running", 32'(running0), 32'd0);
    chk("mrst_done", 32'(done0), 32'd0);
    chk("mrst_dut_in", 32'(dut_in0), 32'd0);
    chk("mrst_mm", 32'(mm0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start;
    wait_done("post_rst");
    chk("post_rst_pass", 32'(pass0), 32'd1);
    chk("post_rst_pass2", 32'(pass2), 32'd1);
    chk("post_rst_mm", 32'(mm0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/vector_checker.md
Name: vector_checker

Overview:
- Synthesisable, parametrised vector player/checker for gate-level DUTs.
- Holds a DEPTH-entry table of {expected output, stimulus}, drives the stimulus into a DUT one vector per clock and compares the DUT output against expected values after a fixed pipeline latency.
- Reports mismatch count, the index of the first failing vector, and pass/done status, so a truth-table check runs on hardware or in simulation without a file-based flow.

Parameters:
- IN_W, 2, stimulus width in bits (DUT input bus).
- OUT_W, 1, DUT output width in bits.
- DEPTH, 4, number of vectors; must be ≥ 2.
- LATENCY, 0, clock cycles from a vector being applied to its DUT output being valid; range 0..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_we  in  1  table write strobe.
- load_addr  in  $clog2(DEPTH)  table write index.
- load_data  in  OUT_W+IN_W  {expected, stimulus} word.
- start  in  1  begin a run.
- abort  in  1  cancel a run.
- dut_in  out  IN_W  stimulus applied to the DUT.
- dut_out  in  OUT_W  DUT response.
- running  out  1  high while in RUN.
- done  out  1  high while in DONE.
- pass  out  1  done && mismatch_count==0.
- mismatch_count  out  $clog2(DEPTH+1)  number of failing vectors.
- first_fail_idx  out  $clog2(DEPTH)  index of the first failing vector; meaningful only when mismatch_count>0.

Behaviour:
- Reset values (async, rst_n low):
  - state=IDLE, dut_in=0, running=0, done=0, pass=0, mismatch_count=0, first_fail_idx=0.
  - Internal issue index and compare pipeline are cleared.
  - Table contents are not reset.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge E0:
  - state→RUN; index k=0; mismatch_count and first_fail_idx cleared.
  - done drops after E0.
- RUN, issue phase:
  - During cycle k (between E_k and E_k+1), dut_in = stimulus[k] (combinational table read).
  - k increments each edge until DEPTH-1.
  - After the last vector, dut_in=0.
- RUN, expected pipeline:
  - Expected value for vector k is delayed LATENCY stages.
  - dut_out is compared against expected[k] at edge E_(k+1+LATENCY).
  - With LATENCY=0 the compare happens at E_(k+1), same-cycle combinational DUT.
- Mismatch handling:
  - Any bit differing counts the whole vector as one mismatch.
  - On the first mismatch of a run, first_fail_idx is captured and is not overwritten by later mismatches.
  - mismatch_count saturates at DEPTH.
- RUN exit:
  - At edge E_(DEPTH+LATENCY), after the final compare is accounted, state→DONE.
  - Total run length is DEPTH+LATENCY cycles.
- Outputs: running=1 exactly in RUN; done=1 in DONE and held until the next start or reset.
- abort:
  - Sampled in RUN: next state is IDLE, dut_in=0, done stays 0.
  - mismatch_count and first_fail_idx retain their partial values.
  - abort in IDLE/DONE has no effect.
- start and abort together in RUN: abort wins. start in RUN (no abort) is ignored.
- Table writes:
  - load_we is accepted only in IDLE or DONE; it is ignored in RUN.
  - load_addr ≥ DEPTH is ignored.
  - A write and a start on the same edge: the write lands before vector 0 is read.
- Reset mid-run: immediate return to the reset values above; no partial done.

Test Plan:
- NAND, LATENCY=0, table {a,b}=00,10,01,11 with expected 1,1,1,0; good NAND DUT; start at E0 → dut_in sequence 00,10,01,11; done=1, pass=1, mismatch_count=0 after E4.
- Same table with an AND DUT → mismatch_count=4, first_fail_idx=0, pass=0.
- Same table with DUT output stuck at 1 → mismatch_count=1, first_fail_idx=3.
- LATENCY=2 with a two-flop registered NAND DUT → pass=1, done after E6; running high for 6 cycles.
- Abort at E2 of a run → state IDLE, done=0, dut_in=0. Restart with start → a full run that passes.
- rst_n low mid-run at cycle 2 → all outputs zero asynchronously. After release, start → a correct run using the retained table.
